// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared widths, limits and capture state type for the tape blocks
package tape_pkg;
    localparam int TIME_W     = 24;
    localparam logic [TIME_W-1:0] TIME_MAX = '1;
    localparam int MIN_PERIOD = 8;
    localparam int DEPTH      = 16;

    typedef enum logic {
        IDLE,
        ARMED
    } cap_state_e;
endpackage

// File: rtl/tape_pulse_capture_if.sv
// rtl/tape_pulse_capture_if.sv - period queue valid/ready handshake
interface tape_pulse_capture_if #(
    parameter int W = tape_pkg::TIME_W
);
    logic [W-1:0] period_data;
    logic         period_valid;
    logic         period_ready;

    modport master (
        output period_data,
        output period_valid,
        input  period_ready
    );

    modport slave (
        input  period_data,
        input  period_valid,
        output period_ready
    );
endinterface

// File: rtl/tape_period_fifo.sv
// rtl/tape_period_fifo.sv - first-word-fall-through period queue with level/full/empty
module tape_period_fifo #(
    parameter int  W     = 24,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    import tape_pkg::*;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_wr, do_rd;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    // A pop frees the slot the same cycle, so a full queue still accepts a write alongside it
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/tape_pulse_capture.sv
// rtl/tape_pulse_capture.sv - times full cycles of the cassette write line and queues the periods
module tape_pulse_capture #(
    parameter int TIME_W     = tape_pkg::TIME_W,
    parameter int DEPTH      = tape_pkg::DEPTH,
    parameter int MIN_PERIOD = tape_pkg::MIN_PERIOD
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   tape_in,
    input  logic                   clear_overflow,
    tape_pulse_capture_if.master   cap_if,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   armed
);
    import tape_pkg::*;

    localparam logic [TIME_W-1:0] T_MAX = '1;
    localparam logic [TIME_W-1:0] T_MIN = TIME_W'(MIN_PERIOD);
    localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1);

    logic              s1_q, s2_q, s3_q;
    logic              edge_det;
    cap_state_e        state_q, state_d;
    logic [TIME_W-1:0] cnt_q, cnt_d;
    logic [TIME_W-1:0] push_data_q, push_data_d;
    logic              push_q, push_d;
    logic              overflow_q, overflow_d;
    logic              fifo_full, fifo_empty, pop, drop;

    // Line idles high through reset so a pin already high is not mistaken for an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= tape_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_det = s2_q && !s3_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (edge_det) begin
                        state_d = ARMED;
                        cnt_d   = T_ONE;
                    end
                end
                ARMED: begin
                    // Short pulses are glitches: the reference edge stays where it was
                    if (edge_det && cnt_q >= T_MIN) begin
                        push_d      = 1'b1;
                        push_data_d = cnt_q;
                        cnt_d       = T_ONE;
                    end else if (cnt_q == T_MAX) begin
                        push_d      = 1'b1;
                        push_data_d = T_MAX;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + T_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pop  = cap_if.period_valid && cap_if.period_ready;
    assign drop = push_q && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q || drop;
        if (clear_overflow) overflow_d = 1'b0;
    end

    tape_period_fifo #(
        .W     (TIME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push_q),
        .wr_data (push_data_q),
        .rd_en   (cap_if.period_ready),
        .rd_data (cap_if.period_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cap_if.period_valid = !fifo_empty;
    assign overflow            = overflow_q;
    assign armed               = (state_q == ARMED);
endmodule

// File: tb/tb_tape_pulse_capture.sv
// tb/tb_tape_pulse_capture.sv - directed self-checking bench for tape_pulse_capture
module tb_tape_pulse_capture;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable_a = 1'b0, tape_a = 1'b0, clr_a = 1'b0;
    logic       enable_b = 1'b0, tape_b = 1'b0, clr_b = 1'b0;
    logic [4:0] level_a, level_b;
    logic       ovf_a, ovf_b, armed_a, armed_b;
    int         total = 0;
    int         bad = 0;

    tape_pulse_capture_if #(.W(24)) if_a ();
    tape_pulse_capture_if #(.W(8))  if_b ();

    tape_pulse_capture #(.TIME_W(24), .DEPTH(16), .MIN_PERIOD(8)) u_dut_a (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable_a),
        .tape_in        (tape_a),
        .clear_overflow (clr_a),
        .cap_if         (if_a),
        .fifo_level     (level_a),
        .overflow       (ovf_a),
        .armed          (armed_a)
    );

    tape_pulse_capture #(.TIME_W(8), .DEPTH(16), .MIN_PERIOD(8)) u_dut_b (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable_b),
        .tape_in        (tape_b),
        .clear_overflow (clr_b),
        .cap_if         (if_b),
        .fifo_level     (level_b),
        .overflow       (ovf_b),
        .armed          (armed_b)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic per_a(input int n);
        tape_a = 1'b1;
        tick(n / 2);
        tape_a = 1'b0;
        tick(n - n / 2);
    endtask

    task automatic pop_a(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, 32'(if_a.period_valid), 32'd1);
        chk(tag, 32'(if_a.period_data), exp);
        if_a.period_ready = 1'b1;
        tick(1);
        if_a.period_ready = 1'b0;
    endtask

    initial begin
        if_a.period_ready = 1'b0;
        if_b.period_ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(if_a.period_valid), 32'd0);
        chk("rst_data", 32'(if_a.period_data), 32'd0);
        chk("rst_level", 32'(level_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_armed", 32'(armed_a), 32'd0);
        reset_n = 1'b1;
        enable_b = 1'b1;
        tick(2);

        // Steady 1000-cycle square wave
        enable_a = 1'b1;
        per_a(1000);
        chk("t1_armed", 32'(armed_a), 32'd1);
        chk("t1_level0", 32'(level_a), 32'd0);
        tape_a = 1'b1;
        tick(3);
        chk("t1_lat3", 32'(if_a.period_valid), 32'd0);
        tick(1);
        chk("t1_lat4", 32'(if_a.period_valid), 32'd1);
        tick(496);
        tape_a = 1'b0;
        tick(500);
        repeat (3) per_a(1000);
        chk("t1_level", 32'(level_a), 32'd4);
        for (int i = 0; i < 4; i++) pop_a("t1_entry", 32'd1000);
        chk("t1_empty", 32'(level_a), 32'd0);

        // Glitch shorter than MIN_PERIOD is ignored
        enable_a = 1'b0;
        tick(2);
        chk("t2_disarm", 32'(armed_a), 32'd0);
        enable_a = 1'b1;
        per_a(500);
        per_a(3);
        per_a(697);
        per_a(10);
        chk("t2_level", 32'(level_a), 32'd2);
        pop_a("t2_e0", 32'd500);
        pop_a("t2_e1", 32'd700);

        // Overflow with consumer stalled
        enable_a = 1'b0;
        tick(2);
        enable_a = 1'b1;
        repeat (21) per_a(200);
        chk("t3_level", 32'(level_a), 32'd16);
        chk("t3_ovf", 32'(ovf_a), 32'd1);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        chk("t3_clr", 32'(ovf_a), 32'd0);

        // Push and pop together while full
        tape_a = 1'b1;
        tick(3);
        if_a.period_ready = 1'b1;
        tick(1);
        if_a.period_ready = 1'b0;
        chk("t5_level", 32'(level_a), 32'd16);
        chk("t5_ovf", 32'(ovf_a), 32'd0);
        tape_a = 1'b0;
        tick(5);
        for (int i = 0; i < 15; i++) pop_a("t3_drain", 32'd200);
        pop_a("t5_tail", 32'd201);
        chk("t3_empty", 32'(if_a.period_valid), 32'd0);

        // Timeout on the 8-bit instance
        tape_b = 1'b1;
        tick(2);
        tape_b = 1'b0;
        tick(1);
        chk("t4_armed", 32'(armed_b), 32'd1);
        tick(250);
        chk("t4_still_armed", 32'(armed_b), 32'd1);
        chk("t4_no_push", 32'(level_b), 32'd0);
        tick(10);
        chk("t4_level", 32'(level_b), 32'd1);
        chk("t4_data", 32'(if_b.period_data), 32'hFF);
        chk("t4_idle", 32'(armed_b), 32'd0);
        tape_b = 1'b1;
        tick(2);
        tape_b = 1'b0;
        tick(8);
        chk("t4_rearm", 32'(armed_b), 32'd1);
        chk("t4_rearm_level", 32'(level_b), 32'd1);
        if_b.period_ready = 1'b1;
        tick(1);
        if_b.period_ready = 1'b0;
        chk("t4_drained", 32'(level_b), 32'd0);

        // Asynchronous reset with entries queued
        enable_a = 1'b0;
        tick(2);
        enable_a = 1'b1;
        repeat (4) per_a(100);
        chk("t6_level", 32'(level_a), 32'd3);
        tape_a = 1'b1;
        tick(20);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(if_a.period_valid), 32'd0);
        chk("t6_rlevel", 32'(level_a), 32'd0);
        chk("t6_armed", 32'(armed_a), 32'd0);
        chk("t6_data", 32'(if_a.period_data), 32'd0);
        tick(1);
        tape_a = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        chk("t6_post_armed", 32'(armed_a), 32'd0);
        per_a(100);
        chk("t6_arm_only", 32'(armed_a), 32'd1);
        chk("t6_no_push", 32'(level_a), 32'd0);
        per_a(100);
        chk("t6_one", 32'(level_a), 32'd1);
        pop_a("t6_entry", 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
